xform_unit_scheduler: RTL and testbench

Round-robin scheduler that shares one fixed-latency transform unit among `NUM_REQ` requesters. It accepts one request at a time over a valid/ready channel and drives the shared unit with a start pulse and held operand. It captures the unit result after `UNIT_LAT` cycles and returns it with the requester ID on a valid/ready response channel. It sits between requester modules and a single shared transform child instance, replacing per-requester copies of that child.

---
 rtl/xform_unit_scheduler.sv | 109 ++++++++++
 tb/tb_xform_unit_scheduler.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/xform_unit_scheduler.sv
// Round-robin front end sharing one fixed-latency transform unit.
// One operation in flight: accept, wait UNIT_LAT cycles, hold response.
module xform_unit_scheduler #(
  parameter int NUM_REQ  = 4,
  parameter int WIDTH    = 8,
  parameter int UNIT_LAT = 1,
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [WIDTH-1:0]         unit_in,
  output logic                     unit_start,
  input  logic [WIDTH-1:0]         unit_out,
  output logic                     rsp_valid,
  output logic [WIDTH-1:0]         rsp_data,
  output logic [ID_W-1:0]          rsp_id,
  input  logic                     rsp_ready,
  output logic                     busy
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam logic [7:0]      LAT  = 8'(UNIT_LAT);
  localparam logic [ID_W-1:0] LAST = ID_W'(NUM_REQ - 1);

  state_t          state;
  logic [ID_W-1:0] ptr;
  logic [7:0]      cnt;

  logic            found;
  logic [ID_W-1:0] win;
  logic [ID_W-1:0] nxt_ptr;

  // first valid bit at or above ptr, wrapping to 0
  always_comb begin
    int idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = ID_W'(idx);
      end
    end
  end

  assign nxt_ptr = (win == LAST) ? '0 : win + 1'b1;

  always_comb begin
    req_ready = '0;
    if (rst_n && state == IDLE && found)
      req_ready = NUM_REQ'(1) << win;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      cnt        <= '0;
      unit_in    <= '0;
      unit_start <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_id     <= '0;
    end else begin
      unit_start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (found) begin
            unit_in    <= req_data[int'(win)*WIDTH +: WIDTH];
            rsp_id     <= win;
            ptr        <= nxt_ptr;
            cnt        <= '0;
            unit_start <= 1'b1;
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == LAT) begin
            rsp_data  <= unit_out;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xform_unit_scheduler.sv
// Bench for xform_unit_scheduler: cycle model plus response scoreboard.
// A second instance exercises the combinational-unit build.
module tb_xform_unit_scheduler;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready;
  logic [7:0]  unit_in;
  logic        unit_start;
  logic [7:0]  unit_out;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic [1:0]  rsp_id;
  logic        rsp_ready = 1'b0;
  logic        busy;

  logic [3:0]  v0 = '0;
  logic [31:0] d0 = '0;
  logic [3:0]  rr0;
  logic [7:0]  ui0;
  logic        us0;
  logic [7:0]  uo0;
  logic        rv0;
  logic [7:0]  rd0;
  logic [1:0]  rid0;
  logic        rsr0 = 1'b1;
  logic        busy0;

  always #5 clk = ~clk;

  xform_unit_scheduler #(.NUM_REQ(4), .WIDTH(8), .UNIT_LAT(LAT)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .unit_in(unit_in), .unit_start(unit_start), .unit_out(unit_out),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .rsp_ready(rsp_ready), .busy(busy)
  );

  xform_unit_scheduler #(.NUM_REQ(4), .WIDTH(8), .UNIT_LAT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(v0), .req_data(d0), .req_ready(rr0),
    .unit_in(ui0), .unit_start(us0), .unit_out(uo0),
    .rsp_valid(rv0), .rsp_data(rd0), .rsp_id(rid0),
    .rsp_ready(rsr0), .busy(busy0)
  );

  // shared unit: ~operand two cycles after start, unknown otherwise
  logic s1 = 1'b0;
  logic s2 = 1'b0;
  always @(posedge clk) begin
    s1 <= unit_start;
    s2 <= s1;
  end
  assign unit_out = s2 ? ~unit_in : 8'hxx;
  assign uo0 = ~ui0;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int mptr = 0;
  bit mbusy = 0;
  int st_cyc = 0;
  int rs_cyc = 0;
  logic [9:0] sb[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] v, input int p);
    for (int i = 0; i < 4; i++)
      if (v[(p + i) % 4]) return (p + i) % 4;
    return -1;
  endfunction

  task automatic step(input logic [3:0] v, input logic [31:0] d,
                      input logic r);
    int w;
    logic [31:0] sh;
    logic [3:0] er;
    @(posedge clk);
    #1;
    req_valid = v;
    req_data  = d;
    rsp_ready = r;
    @(negedge clk);
    cyc++;
    chk("busy", 32'(busy), 32'(mbusy));
    if (!mbusy) begin
      w  = pick(v, mptr);
      er = (w < 0) ? 4'd0 : 4'(1 << w);
      chk("req_ready", 32'(req_ready), 32'(er));
      chk("idle_rsp_valid", 32'(rsp_valid), 0);
      if (w >= 0) begin
        sh = d >> (w * 8);
        sb.push_back({2'(w), ~sh[7:0]});
        mptr   = (w + 1) % 4;
        mbusy  = 1;
        st_cyc = cyc + 1;
        rs_cyc = cyc + 2 + LAT;
      end
    end else begin
      chk("busy_req_ready", 32'(req_ready), 0);
      chk("unit_start", 32'(unit_start), 32'(cyc == st_cyc));
      chk("rsp_valid", 32'(rsp_valid), 32'(cyc >= rs_cyc));
      if (cyc >= rs_cyc && r) mbusy = 0;
    end
  endtask

  task automatic reset_checks();
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_unit_start", 32'(unit_start), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_unit_in", 32'(unit_in), 0);
    chk("rst_rsp_data", 32'(rsp_data), 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    req_valid = 4'hF;
    #1;
    reset_checks();
    sb.delete();
    mbusy = 0;
    mptr  = 0;
    @(negedge clk);
    req_valid = 4'h0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // response monitor
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rsp_unexpected cyc=%0d id=%0d data=%0h",
                   cyc, rsp_id, rsp_data);
        end else begin
          chk("rsp_data", 32'(rsp_data), 32'(sb[0][7:0]));
          chk("rsp_id", 32'(rsp_id), 32'(sb[0][9:8]));
          if (rsp_ready) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    req_valid = 4'hF;
    #12;
    reset_checks();
    req_valid = 4'h0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // combinational-unit build: accept at T, response at T+2
    @(posedge clk);
    #1;
    v0 = 4'b1000;
    d0 = 32'hF000_0000;
    @(negedge clk);
    chk("lat0_ready", 32'(rr0), 32'h8);
    @(posedge clk);
    #1;
    v0 = 4'b0000;
    @(negedge clk);
    chk("lat0_start", 32'(us0), 1);
    chk("lat0_early", 32'(rv0), 0);
    @(negedge clk);
    chk("lat0_valid", 32'(rv0), 1);
    chk("lat0_data", 32'(rd0), 32'h0F);
    chk("lat0_id", 32'(rid0), 3);
    chk("lat0_idle_ready", 32'(rr0), 0);

    // single request
    step(4'b0001, 32'h0000_005A, 1'b1);
    repeat (6) step(4'b0000, 32'h0, 1'b1);

    // full contention
    repeat (26) step(4'b1111, $urandom, 1'b1);
    repeat (6) step(4'b0000, 32'h0, 1'b1);

    // pointer wrap: grant 2, then 1001 gives 3 then 0
    pulse_reset();
    step(4'b0100, $urandom, 1'b1);
    repeat (5) step(4'b0000, 32'h0, 1'b1);
    repeat (12) step(4'b1001, $urandom, 1'b1);
    repeat (6) step(4'b0000, 32'h0, 1'b1);

    // backpressure
    step(4'b0010, 32'h0000_3300, 1'b0);
    repeat (14) step(4'b1111, $urandom, 1'b0);
    repeat (8) step(4'b1111, $urandom, 1'b1);
    repeat (6) step(4'b0000, 32'h0, 1'b1);

    // reset in second WAIT cycle
    step(4'b0100, $urandom, 1'b1);
    step(4'b0000, 32'h0, 1'b1);
    pulse_reset();
    step(4'b1111, $urandom, 1'b1);
    repeat (6) step(4'b0000, 32'h0, 1'b1);

    // random traffic
    repeat (300)
      step(4'($urandom), $urandom, ($urandom_range(0, 3) != 0));
    repeat (12) step(4'b0000, 32'h0, 1'b1);
    chk("sb_empty", 32'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
